ne16_input_buffer_dbuf: RTL
===========================

NE16_INPUT_BUFFER_DBUF -- requirements
Module: ne16_input_buffer_dbuf

Interface
REQ-001 SHALL have parameter NW, default 25: words per bank.
REQ-002 SHALL have parameter BLOCK_SIZE, default 16: channels per word.
REQ-003 SHALL have parameter DW, default 8: bits per channel.
REQ-004 SHALL have one clock and an asynchronous active-low reset:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have the following remaining ports:
- test_mode_i  in  1  DFT; no functional effect.
- enable_i  in  1  global enable; low freezes all state and forces every ready/valid low.
- clear_i  in  1  synchronous soft clear.
- goto_load_i  in  1  load request pulse.
- load_len_i  in  $clog2(NW)+1  words to load; 0 means NW.
- load_mask_i  in  NW  per-word 1 = fetch from stream, 0 = skip.
- impl_pad_i  in  NW  per-word implicit padding.
- expl_pad_i  in  NW  per-word explicit padding.
- pad_lo_i / pad_hi_i  in  DW  explicit padding value for even / odd channels.
- release_i  in  1  consumer done with read bank.
- feat_i  sink  BLOCK_SIZE x hwpe_stream  input words.
- feat_o  source  NW*BLOCK_SIZE x hwpe_stream  buffer contents.
- state_o  out  1  write FSM state (0 W_IDLE, 1 W_LOAD).
- full_o  out  2  per-bank full flags.
- wr_bank_o / rd_bank_o  out  1 each  bank pointers.

Function
REQ-006 SHALL hold two banks of NW x BLOCK_SIZE x DW flip-flops; feat_o[w*BLOCK_SIZE+c].data = rd bank word w, channel c; strb all ones.
REQ-007 feat_o valid (all lanes, broadcast) SHALL equal full[rd_bank] & enable_i.
REQ-008 All feat_i ready SHALL be broadcast from one signal: (state==W_LOAD) & load_mask_i[cnt] & enable_i.
REQ-009 W_IDLE->W_LOAD SHALL occur when (goto_load_i | pending) & ~full[wr_bank]; cnt cleared on entry.
REQ-010 goto_load_i in W_IDLE with full[wr_bank]=1 SHALL set pending; pending clears on entry to W_LOAD; goto_load_i in W_LOAD SHALL be ignored.
REQ-011 In W_LOAD, word cnt SHALL be written when load_mask_i[cnt]=1 and feat_i[0] valid&ready, or when load_mask_i[cnt]=0 on any enabled cycle (no stream consumption); cnt increments on each write.
REQ-012 Written data SHALL be: impl_pad_i[cnt] -> 0; else expl_pad_i[cnt] -> pad_lo_i/pad_hi_i on even/odd channels; else load_mask_i[cnt]=0 -> 0; else feat_i data.
REQ-013 On the write of word load_len-1: full[wr_bank] set, wr_bank toggles, state returns W_IDLE, cnt cleared, all in the same edge.
REQ-014 release_i with full[rd_bank]=1 SHALL clear full[rd_bank] and toggle rd_bank; release_i with full[rd_bank]=0 SHALL be ignored.
REQ-015 Load completion and release on the same cycle SHALL both take effect; a bank freed by release is loadable on the next cycle.
REQ-016 clear_i SHALL set state W_IDLE, cnt 0, pending 0, full 00, both pointers 0; bank data retained; clear_i has priority over every other event.

Reset
REQ-017 rst_ni low SHALL asynchronously set state W_IDLE, cnt 0, pending 0, full 00, wr_bank 0, rd_bank 0, all bank data 0; hence all ready/valid 0.
REQ-018 Reset mid-load SHALL discard the partial load; the bank is not marked full.

Configuration
REQ-019 Macro NE16_IBUF_DBUF_EN defined: two banks as above.
REQ-020 Macro undefined: one bank; wr_bank_o/rd_bank_o tied 0, full_o[1] tied 0; loading is blocked (pending) until release; all other rules unchanged.

Verification
REQ-021 Reset, then idle -> all feat_o valid 0, feat_i ready 0, full_o=00.
REQ-022 goto_load, load_len=25, mask all 1, 25 words with value w -> full_o=01, wr_bank_o=1; feat_o[w*16+c].data=w.
REQ-023 load_mask=0x1CE7 (3x3 in 5x5), load_len=25 -> exactly 9 handshakes, 25 writes, unmasked words read 0.
REQ-024 impl_pad[0]=1, expl_pad[1]=1, pad_lo=0x11, pad_hi=0x22 -> word0 all 0, word1 channels alternate 0x11/0x22.
REQ-025 DBUF_EN: load bank0, load bank1, third goto_load -> pending, ready 0; release -> load starts next cycle into bank0; release with load-end same cycle -> full_o=10 correct.
REQ-026 clear_i at word 10 of load -> W_IDLE, full_o=00, next load restarts at word 0.

Source files
------------

// File: rtl/ne16_input_buffer_dbuf.sv
// NE16 input feature buffer: NW-word banks loaded from a BLOCK_SIZE-lane stream with masking/padding.
// Define NE16_IBUF_DBUF_EN for two ping-pong banks; otherwise a single bank is used.
module ne16_input_buffer_dbuf #(
    parameter int unsigned NW         = 25,
    parameter int unsigned BLOCK_SIZE = 16,
    parameter int unsigned DW         = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     test_mode_i,
    input  logic                                     enable_i,
    input  logic                                     clear_i,
    input  logic                                     goto_load_i,
    input  logic [$clog2(NW):0]                      load_len_i,
    input  logic [NW-1:0]                            load_mask_i,
    input  logic [NW-1:0]                            impl_pad_i,
    input  logic [NW-1:0]                            expl_pad_i,
    input  logic [DW-1:0]                            pad_lo_i,
    input  logic [DW-1:0]                            pad_hi_i,
    input  logic                                     release_i,
    input  logic [BLOCK_SIZE-1:0][DW-1:0]            feat_i_data,
    input  logic [BLOCK_SIZE-1:0][(DW+7)/8-1:0]      feat_i_strb,
    input  logic [BLOCK_SIZE-1:0]                    feat_i_valid,
    output logic [BLOCK_SIZE-1:0]                    feat_i_ready,
    output logic [NW*BLOCK_SIZE-1:0][DW-1:0]         feat_o_data,
    output logic [NW*BLOCK_SIZE-1:0][(DW+7)/8-1:0]   feat_o_strb,
    output logic [NW*BLOCK_SIZE-1:0]                 feat_o_valid,
    input  logic [NW*BLOCK_SIZE-1:0]                 feat_o_ready,
    output logic                                     state_o,
    output logic [1:0]                               full_o,
    output logic                                     wr_bank_o,
    output logic                                     rd_bank_o
);

`ifdef NE16_IBUF_DBUF_EN
    localparam int unsigned NB   = 2;
    localparam logic        DBUF = 1'b1;
`else
    localparam int unsigned NB   = 1;
    localparam logic        DBUF = 1'b0;
`endif

    localparam int unsigned CW = $clog2(NW);
    localparam int unsigned LW = CW + 1;
    localparam int unsigned AW = $clog2(NB * NW);

    typedef enum logic {WIdle, WLoad} wstate_e;
    typedef logic [BLOCK_SIZE-1:0][DW-1:0] word_t;

    wstate_e         state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    word_t           bank_q [NB*NW];

    logic [LW-1:0]   len_eff;
    logic            mask_bit, ready, wr_en, last, rel_fire;
    logic [AW-1:0]   waddr;
    word_t           wdata;

    // Out-of-range lengths fall back to a full bank, like 0.
    assign len_eff  = (load_len_i == '0 || load_len_i > LW'(NW)) ? LW'(NW) : load_len_i;
    assign mask_bit = load_mask_i[cnt_q];
    assign ready    = (state_q == WLoad) & mask_bit & enable_i;
    // Skipped words are written every enabled cycle without touching the stream.
    assign wr_en    = enable_i & (state_q == WLoad) & (mask_bit ? (feat_i_valid[0] & ready) : 1'b1);
    assign last     = ({1'b0, cnt_q} == len_eff - LW'(1));
    assign rel_fire = enable_i & release_i & full_q[rd_bank_q];
    assign waddr    = AW'(cnt_q) + (wr_bank_q ? AW'(NW) : AW'(0));

    always_comb begin
        wdata = '0;
        for (int c = 0; c < int'(BLOCK_SIZE); c++) begin
            if (impl_pad_i[cnt_q]) begin
                wdata[c] = '0;
            end else if (expl_pad_i[cnt_q]) begin
                wdata[c] = (c % 2 == 1) ? pad_hi_i : pad_lo_i;
            end else if (!mask_bit) begin
                wdata[c] = '0;
            end else begin
                wdata[c] = feat_i_data[c];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (clear_i) begin
            state_d   = WIdle;
            cnt_d     = '0;
            pending_d = 1'b0;
            full_d    = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
        end else if (enable_i) begin
            if (rel_fire) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = rd_bank_q ^ DBUF;
            end
            unique case (state_q)
                WIdle: begin
                    if ((goto_load_i | pending_q) & ~full_q[wr_bank_q]) begin
                        state_d   = WLoad;
                        cnt_d     = '0;
                        pending_d = 1'b0;
                    end else if (goto_load_i) begin
                        pending_d = 1'b1;
                    end
                end
                WLoad: begin
                    if (wr_en) begin
                        if (last) begin
                            full_d[wr_bank_q] = 1'b1;
                            wr_bank_d         = wr_bank_q ^ DBUF;
                            state_d           = WIdle;
                            cnt_d             = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= WIdle;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NB * NW; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en & ~clear_i) begin
            bank_q[waddr] <= wdata;
        end
    end

    always_comb begin
        feat_o_data = '0;
        for (int unsigned w = 0; w < NW; w++) begin
            feat_o_data[w*BLOCK_SIZE +: BLOCK_SIZE] = bank_q[AW'(w) + (rd_bank_q ? AW'(NW) : AW'(0))];
        end
    end

    assign feat_o_strb  = '1;
    assign feat_o_valid = {(NW * BLOCK_SIZE){full_q[rd_bank_q] & enable_i}};
    assign feat_i_ready = {BLOCK_SIZE{ready}};
    assign state_o      = (state_q == WLoad);
    assign full_o       = full_q;
    assign wr_bank_o    = wr_bank_q;
    assign rd_bank_o    = rd_bank_q;

    logic unused_inputs;
    assign unused_inputs = ^{test_mode_i, feat_i_strb, feat_i_valid[BLOCK_SIZE-1:1], feat_o_ready};

endmodule
